lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 165 ++++++++++++++++
 tb/tb_lsu.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// ============================================================================
//  Module      : lsu
//  Description : Load/store unit. Splits 16/32/64-bit accesses into 16-bit
//                Wishbone beats, highest address first, and assembles the
//                acknowledged read data into a zero-extended 64-bit result.
//                With nomem_i set, the address operand is passed straight to
//                writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lsu (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] dat_i,
    input  logic        we_i,
    input  logic        nomem_i,
    input  logic        hword_i,
    input  logic        word_i,
    input  logic        dword_i,
    output logic        busy_o,
    output logic        rwe_o,
    output logic [63:0] dat_o,
    output logic [63:0] wbmadr_o,
    output logic [15:0] wbmdat_o,
    output logic        wbmwe_o,
    output logic        wbmstb_o,
    input  logic        wbmack_i,
    input  logic [15:0] wbmdat_i
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      state_q,  state_d;
    logic        rwe_q,    rwe_d;
    logic [63:0] dat_q,    dat_d;
    logic [63:0] adr_q,    adr_d;
    logic [15:0] wdat_q,   wdat_d;
    logic        we_q,     we_d;
    logic        stb_q,    stb_d;
    logic [63:0] base_q,   base_d;    // latched effective address
    logic [63:0] store_q,  store_d;   // latched store data
    logic [1:0]  beat_q,   beat_d;    // index of the beat currently on the bus
    logic [2:0]  acks_q,   acks_d;    // acknowledges still outstanding

    logic        w_start;
    logic [1:0]  w_top_beat;
    logic [1:0]  w_next_beat;

    // Size decode: dword wins over word, word over hword; top beat is N-1.
    assign w_start     = hword_i | word_i | dword_i;
    assign w_top_beat  = dword_i ? 2'd3 : (word_i ? 2'd1 : 2'd0);
    assign w_next_beat = beat_q - 2'd1;

    // Every output is a flop; busy is simply the state register.
    assign busy_o   = (state_q == S_BUSY);
    assign rwe_o    = rwe_q;
    assign dat_o    = dat_q;
    assign wbmadr_o = adr_q;
    assign wbmdat_o = wdat_q;
    assign wbmwe_o  = we_q;
    assign wbmstb_o = stb_q;

    // Next-state logic: idle pass-through / start, then request and ack tracking.
    always_comb begin
        state_d = state_q;
        rwe_d   = rwe_q;
        dat_d   = dat_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        we_d    = we_q;
        stb_d   = stb_q;
        base_d  = base_q;
        store_d = store_q;
        beat_d  = beat_q;
        acks_d  = acks_q;

        case (state_q)
            S_IDLE: begin
                if (nomem_i) begin
                    dat_d = addr_i;
                    rwe_d = 1'b1;
                end else if (w_start) begin
                    // The first beat goes out together with busy on this edge.
                    state_d = S_BUSY;
                    base_d  = addr_i;
                    store_d = dat_i;
                    we_d    = we_i;
                    dat_d   = 64'd0;
                    rwe_d   = 1'b0;
                    stb_d   = 1'b1;
                    beat_d  = w_top_beat;
                    adr_d   = addr_i + {61'd0, w_top_beat, 1'b0};
                    wdat_d  = dat_i[{w_top_beat, 4'b0000} +: 16];
                    acks_d  = {1'b0, w_top_beat} + 3'd1;
                end else begin
                    rwe_d = 1'b0;
                end
            end

            S_BUSY: begin
                rwe_d = 1'b0;
                // Step down through the beats; after beat 0 the bus address/data hold.
                if (stb_q) begin
                    if (beat_q == 2'd0) begin
                        stb_d = 1'b0;
                    end else begin
                        beat_d = w_next_beat;
                        adr_d  = base_q + {61'd0, w_next_beat, 1'b0};
                        wdat_d = store_q[{w_next_beat, 4'b0000} +: 16];
                    end
                end
                // Acks may arrive while strobes are still going out.
                if (wbmack_i) begin
                    dat_d  = {dat_q[47:0], wbmdat_i};
                    acks_d = acks_q - 3'd1;
                    if (acks_q == 3'd1) begin
                        state_d = S_IDLE;
                        rwe_d   = ~we_q;
                        stb_d   = 1'b0;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset that also abandons any transfer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            rwe_q   <= 1'b0;
            dat_q   <= 64'd0;
            adr_q   <= 64'd0;
            wdat_q  <= 16'd0;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
            base_q  <= 64'd0;
            store_q <= 64'd0;
            beat_q  <= 2'd0;
            acks_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            rwe_q   <= rwe_d;
            dat_q   <= dat_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            we_q    <= we_d;
            stb_q   <= stb_d;
            base_q  <= base_d;
            store_q <= store_d;
            beat_q  <= beat_d;
            acks_q  <= acks_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
//  Module      : tb_lsu
//  Description : Self-checking bench for lsu. A driver issues directed and
//                random operations and pushes the expected bus beats and
//                results into queues; a monitor compares them against the
//                DUT whenever the DUT presents strobes or results.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lsu;

    logic        clk = 1'b0;
    logic        reset_i, we_i, nomem_i, hword_i, word_i, dword_i, wbmack_i;
    logic [63:0] addr_i, dat_i;
    logic [15:0] wbmdat_i;
    logic        busy_o, rwe_o, wbmwe_o, wbmstb_o;
    logic [63:0] dat_o, wbmadr_o;
    logic [15:0] wbmdat_o;

    always #5 clk = ~clk;

    lsu dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .addr_i   (addr_i),
        .dat_i    (dat_i),
        .we_i     (we_i),
        .nomem_i  (nomem_i),
        .hword_i  (hword_i),
        .word_i   (word_i),
        .dword_i  (dword_i),
        .busy_o   (busy_o),
        .rwe_o    (rwe_o),
        .dat_o    (dat_o),
        .wbmadr_o (wbmadr_o),
        .wbmdat_o (wbmdat_o),
        .wbmwe_o  (wbmwe_o),
        .wbmstb_o (wbmstb_o),
        .wbmack_i (wbmack_i),
        .wbmdat_i (wbmdat_i)
    );

    typedef struct {
        logic [63:0] adr;
        logic [15:0] dat;
        logic        we;
    } beat_t;

    typedef struct {
        logic [63:0] res;
        logic        rwe;
    } done_t;

    beat_t       beat_q[$];
    done_t       done_q[$];
    logic [63:0] pass_q[$];
    logic [63:0] last_dat;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    initial begin : monitor
        beat_t       b;
        done_t       dn;
        logic [63:0] v;
        logic        rst_s;
        logic        busy_prev;
        logic        comp;
        busy_prev = 1'b0;
        last_dat  = 64'd0;
        forever begin
            @(posedge clk);
            rst_s = reset_i;
            #1;
            if (rst_s) begin
                chk("rst_busy",  64'(busy_o),   64'd0);
                chk("rst_rwe",   64'(rwe_o),    64'd0);
                chk("rst_stb",   64'(wbmstb_o), 64'd0);
                chk("rst_we",    64'(wbmwe_o),  64'd0);
                chk("rst_dat",   dat_o,         64'd0);
                chk("rst_adr",   wbmadr_o,      64'd0);
                chk("rst_wdat",  64'(wbmdat_o), 64'd0);
                busy_prev = 1'b0;
                last_dat  = 64'd0;
            end else begin
                comp = busy_prev && !busy_o;
                if (beat_q.size() > 0) begin
                    if (!wbmstb_o) begin
                        chk("stb_expected", 64'(wbmstb_o), 64'd1);
                    end else begin
                        b = beat_q.pop_front();
                        chk("beat_adr",  wbmadr_o,      b.adr);
                        chk("beat_dat",  64'(wbmdat_o), 64'(b.dat));
                        chk("beat_we",   64'(wbmwe_o),  64'(b.we));
                        chk("beat_busy", 64'(busy_o),   64'd1);
                    end
                end else if (wbmstb_o) begin
                    chk("stb_unexpected", 64'(wbmstb_o), 64'd0);
                end

                if (comp) begin
                    if (done_q.size() == 0) begin
                        chk("done_unexpected", 64'(busy_o), 64'd1);
                    end else begin
                        dn = done_q.pop_front();
                        chk("done_dat", dat_o,       dn.res);
                        chk("done_rwe", 64'(rwe_o),  64'(dn.rwe));
                        last_dat = dn.res;
                    end
                end else if (busy_o) begin
                    chk("busy_rwe", 64'(rwe_o), 64'd0);
                end else if (pass_q.size() > 0) begin
                    v = pass_q.pop_front();
                    chk("pass_rwe", 64'(rwe_o), 64'd1);
                    chk("pass_dat", dat_o,      v);
                    last_dat = v;
                end else begin
                    chk("idle_rwe",  64'(rwe_o), 64'd0);
                    chk("idle_hold", dat_o,      last_dat);
                end
                busy_prev = busy_o;
            end
        end
    end

    // ----------------------------------------------------------------- driver
    task automatic rand_inputs();
        addr_i  = {$urandom, $urandom};
        dat_i   = {$urandom, $urandom};
        we_i    = 1'($urandom);
        nomem_i = 1'($urandom);
        hword_i = 1'($urandom);
        word_i  = 1'($urandom);
        dword_i = 1'($urandom);
    endtask

    task automatic apply_reset();
        reset_i  = 1'b1;
        wbmack_i = 1'b0;
        beat_q.delete();
        done_q.delete();
        pass_q.delete();
        @(posedge clk);
    endtask

    task automatic op_idle();
        @(negedge clk);
        reset_i  = 1'b0;
        rand_inputs();
        nomem_i  = 1'b0;
        hword_i  = 1'b0;
        word_i   = 1'b0;
        dword_i  = 1'b0;
        wbmack_i = 1'($urandom);
        wbmdat_i = 16'($urandom);
        @(posedge clk);
    endtask

    task automatic op_pass(input logic [63:0] a);
        @(negedge clk);
        reset_i  = 1'b0;
        rand_inputs();
        nomem_i  = 1'b1;
        addr_i   = a;
        wbmack_i = 1'($urandom);
        wbmdat_i = 16'($urandom);
        pass_q.push_back(a);
        @(posedge clk);
    endtask

    // One memory access of n beats; abort_at >= 0 asserts reset that many cycles in.
    task automatic op_mem(input int n, input logic [63:0] a, input logic [63:0] d,
                          input logic w, input logic [3:0][15:0] ackv, input int abort_at);
        beat_t       b;
        done_t       dn;
        logic [63:0] res;
        int          acks;
        int          stbs;
        int          cyc;
        @(negedge clk);
        reset_i  = 1'b0;
        nomem_i  = 1'b0;
        addr_i   = a;
        dat_i    = d;
        we_i     = w;
        dword_i  = (n == 4);
        word_i   = (n == 2) || (n == 4 && 1'($urandom));
        hword_i  = (n == 1) || 1'($urandom);
        wbmack_i = 1'($urandom);
        wbmdat_i = 16'($urandom);
        for (int k = n - 1; k >= 0; k--) begin
            b.adr = a + 64'(2 * k);
            b.dat = d[16 * k +: 16];
            b.we  = w;
            beat_q.push_back(b);
        end
        res = 64'd0;
        for (int i = 0; i < n; i++) res = (res << 16) | 64'(ackv[i]);
        dn.res = res;
        dn.rwe = !w;
        done_q.push_back(dn);
        @(posedge clk);

        acks = 0;
        stbs = 0;
        cyc  = 0;
        while (acks < n) begin
            @(negedge clk);
            rand_inputs();
            if (cyc == abort_at) begin
                apply_reset();
                return;
            end
            if (wbmstb_o) stbs++;
            if (acks < stbs && ($urandom % 3) != 0) begin
                wbmack_i = 1'b1;
                wbmdat_i = ackv[acks];
                acks++;
            end else begin
                wbmack_i = 1'b0;
                wbmdat_i = 16'($urandom);
            end
            @(posedge clk);
            cyc++;
            if (cyc > 60) begin
                compared++;
                mismatched++;
                $display("FAIL mem_timeout: got %0d acks expected %0d", acks, n);
                @(negedge clk);
                apply_reset();
                return;
            end
        end
    endtask

    localparam logic [63:0] C_A = 64'h1122334455667788;
    localparam logic [63:0] C_D = 64'h7766554433221100;

    initial begin : driver
        logic [3:0][15:0] ackv;
        logic [63:0]      a;
        int               n;
        int               r;
        reset_i  = 1'b1;
        addr_i   = 64'd0;
        dat_i    = 64'd0;
        we_i     = 1'b0;
        nomem_i  = 1'b0;
        hword_i  = 1'b0;
        word_i   = 1'b0;
        dword_i  = 1'b0;
        wbmack_i = 1'b0;
        wbmdat_i = 16'd0;
        repeat (2) @(posedge clk);

        // Directed cases.
        op_pass(C_A);
        op_idle();
        op_mem(1, C_A, C_D, 1'b1, {16'h0, 16'h0, 16'h0, 16'hDEAD}, -1);
        op_mem(2, C_A, C_D, 1'b1, {16'h0, 16'h0, 16'hBEEF, 16'hDEAD}, -1);
        op_mem(4, C_A, C_D, 1'b1, {16'hC0DE, 16'h0BAD, 16'hBEEF, 16'hDEAD}, -1);
        op_mem(1, C_A, C_D, 1'b0, {16'h0, 16'h0, 16'h0, 16'h1234}, -1);
        op_idle();
        op_mem(4, C_A, C_D, 1'b1, {16'hC0DE, 16'h0BAD, 16'hBEEF, 16'hDEAD}, 2);
        op_mem(1, C_A, C_D, 1'b0, {16'h0, 16'h0, 16'h0, 16'h5A5A}, -1);
        op_mem(4, 64'hFFFF_FFFF_FFFF_FFFC, C_D, 1'b0, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, -1);

        // Random mix of idle, pass-through, accesses and aborted accesses.
        for (int it = 0; it < 300; it++) begin
            r = $urandom % 10;
            for (int i = 0; i < 4; i++) ackv[i] = 16'($urandom);
            n = ($urandom % 3 == 0) ? 1 : (($urandom % 2 == 0) ? 2 : 4);
            a = ($urandom % 8 == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16))
                                    : {$urandom, $urandom};
            if (r < 2)       op_idle();
            else if (r < 4)  op_pass({$urandom, $urandom});
            else if (r == 4) op_mem(n, a, {$urandom, $urandom}, 1'($urandom), ackv,
                                    int'($urandom % 4));
            else             op_mem(n, a, {$urandom, $urandom}, 1'($urandom), ackv, -1);
        end

        repeat (3) op_idle();
        chk("beats_left",   64'(beat_q.size()), 64'd0);
        chk("results_left", 64'(done_q.size()), 64'd0);
        chk("pass_left",    64'(pass_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
